snn_inference_sequencer: RTL and testbench

Top-level controller for one inference pass of the bin-ratio ensemble SNN. It streams pre-processed input values from a host into the spike-generation layer's input memory and pulses `pre_processing_done` to start spike generation. It then counts timesteps via `current_step_finished`, requests the winner from the spiking layer after the configured number of steps, and latches and holds the resulting class ID for the host. It replaces the manual stimulus sequencing currently done by hand around the spike generator and the spiking layer.

---
 rtl/snn_ctrl_pkg.sv | 24 ++
 rtl/snn_step_watchdog.sv | 46 ++++
 rtl/snn_inference_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_snn_inference_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg
//   Shared types and default sizing for the SNN inference sequencer.
//   seq_state_t : sequencer FSM states
//   SNN_*       : default parameter values used by the sequencer top
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_KICK = 3'd2,
    ST_RUN  = 3'd3,
    ST_REQ  = 3'd4,
    ST_WAIT = 3'd5,
    ST_DONE = 3'd6
  } seq_state_t;

  localparam int unsigned SNN_NUM_INPUTS     = 32'd1023;
  localparam int unsigned SNN_ADDR_W         = 32'd10;
  localparam int unsigned SNN_DAT_W          = 32'd8;
  localparam int unsigned SNN_NUM_STEPS      = 32'd32;
  localparam int unsigned SNN_ID_W           = 32'd5;
  localparam int unsigned SNN_TIMEOUT_CYCLES = 32'd8192;

endpackage

// File: rtl/snn_step_watchdog.sv
// snn_step_watchdog
//   Down-counting watchdog for the inference sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with TIMEOUT_CYCLES
//   tick       : count down one cycle (only while the guarded phase is active)
//   expired    : the count reaches zero on this tick (combinational, the
//                sequencer registers the resulting error flag)
module snn_step_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd8192
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next counter value: reload wins over counting, stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    end else if (tick && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // fires on the tick that takes the count from 1 to 0
  assign expired = tick & ~load & (cnt_q == CNT_W'(1));

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer
//   Runs one inference pass: streams host data into the spike generator's
//   input memory, kicks spike generation, counts timesteps, requests the
//   winner and latches the class ID for the host.
//   Optional watchdog: define SNN_SEQ_WATCHDOG_EN.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start                              begin inference (IDLE/DONE only)
//   host_dat/host_valid/host_ready     host input stream
//   load_addr/load_en/load_dat         input-memory write port
//   pre_processing_done                one-cycle kick to spike generation
//   current_step_finished              one pulse per completed timestep
//   get_winner                         one-cycle winner request
//   infer_ready/winner_id              winner from the spiking layer
//   result_id/result_valid             latched winner for the host
//   busy                               any state other than IDLE/DONE
//   error                              watchdog expired
module snn_inference_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INPUTS     = SNN_NUM_INPUTS,
  parameter int unsigned ADDR_W         = SNN_ADDR_W,
  parameter int unsigned DAT_W          = SNN_DAT_W,
  parameter int unsigned NUM_STEPS      = SNN_NUM_STEPS,
  parameter int unsigned ID_W           = SNN_ID_W,
  parameter int unsigned TIMEOUT_CYCLES = SNN_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DAT_W-1:0]  host_dat,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_en,
  output logic [DAT_W-1:0]  load_dat,
  output logic              pre_processing_done,
  input  logic              current_step_finished,
  output logic              get_winner,
  input  logic              infer_ready,
  input  logic [ID_W-1:0]   winner_id,
  output logic [ID_W-1:0]   result_id,
  output logic              result_valid,
  output logic              busy,
  output logic              error
);

  localparam int unsigned STEP_W = $clog2(NUM_STEPS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(NUM_STEPS);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STEP_W-1:0] step_q, step_d, step_inc_s;
  logic              host_ready_q, host_ready_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic              load_en_q, load_en_d;
  logic [DAT_W-1:0]  load_dat_q, load_dat_d;
  logic              ppd_q, ppd_d;
  logic              get_winner_q, get_winner_d;
  logic [ID_W-1:0]   result_id_q, result_id_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic              wd_load_s, wd_tick_s, wd_expired_s;

  // saturating step increment: never wraps past NUM_STEPS
  assign step_inc_s = (step_q == STEP_MAX) ? step_q : step_q + STEP_W'(1);

  // next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    step_d         = step_q;
    host_ready_d   = host_ready_q;
    load_addr_d    = load_addr_q;
    load_en_d      = 1'b0;
    load_dat_d     = load_dat_q;
    ppd_d          = 1'b0;
    get_winner_d   = 1'b0;
    result_id_d    = result_id_q;
    result_valid_d = result_valid_q;
    error_d        = error_q;
    wd_load_s      = 1'b0;
    wd_tick_s      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          result_valid_d = 1'b0;
          error_d        = 1'b0;
          addr_d         = {ADDR_W{1'b0}};
          step_d         = {STEP_W{1'b0}};
          host_ready_d   = 1'b1;
          state_d        = ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (host_valid && host_ready_q) begin
          load_en_d   = 1'b1;
          load_addr_d = addr_q;
          load_dat_d  = host_dat;
          if (addr_q == LAST_ADDR) begin
            // ready drops together with the last write strobe
            host_ready_d = 1'b0;
            state_d      = ST_KICK;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          load_en_d = 1'b0;
        end
      end
      ST_KICK: begin
        ppd_d     = 1'b1;
        wd_load_s = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        wd_tick_s = 1'b1;
        if (current_step_finished) begin
          wd_load_s = 1'b1;
          step_d    = step_inc_s;
          if (step_inc_s == STEP_MAX) begin
            get_winner_d = 1'b1;
            state_d      = ST_REQ;
          end else begin
            state_d = ST_RUN;
          end
        end else if (wd_expired_s) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REQ: begin
        wd_load_s = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        wd_tick_s = 1'b1;
        if (infer_ready) begin
          result_id_d    = winner_id;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else if (wd_expired_s) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        host_ready_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
  end

`ifdef SNN_SEQ_WATCHDOG_EN
  snn_step_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wd_load_s),
    .tick    (wd_tick_s),
    .expired (wd_expired_s)
  );
`else
  logic unused_wd_s;
  assign wd_expired_s = 1'b0;
  assign unused_wd_s  = wd_load_s | wd_tick_s;
`endif

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= {ADDR_W{1'b0}};
      step_q         <= {STEP_W{1'b0}};
      host_ready_q   <= 1'b0;
      load_addr_q    <= {ADDR_W{1'b0}};
      load_en_q      <= 1'b0;
      load_dat_q     <= {DAT_W{1'b0}};
      ppd_q          <= 1'b0;
      get_winner_q   <= 1'b0;
      result_id_q    <= {ID_W{1'b0}};
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      step_q         <= step_d;
      host_ready_q   <= host_ready_d;
      load_addr_q    <= load_addr_d;
      load_en_q      <= load_en_d;
      load_dat_q     <= load_dat_d;
      ppd_q          <= ppd_d;
      get_winner_q   <= get_winner_d;
      result_id_q    <= result_id_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
    end
  end

  assign host_ready          = host_ready_q;
  assign load_addr           = load_addr_q;
  assign load_en             = load_en_q;
  assign load_dat            = load_dat_q;
  assign pre_processing_done = ppd_q;
  assign get_winner          = get_winner_q;
  assign result_id           = result_id_q;
  assign result_valid        = result_valid_q;
  assign busy                = busy_q;
  assign error               = error_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Self-checking bench for snn_inference_sequencer (NUM_STEPS=4, TIMEOUT_CYCLES=16).
module tb_snn_inference_sequencer;
  localparam int NI = 1023;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int IW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] host_dat;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] load_addr;
  logic          load_en;
  logic [DW-1:0] load_dat;
  logic          pre_processing_done;
  logic          current_step_finished;
  logic          get_winner;
  logic          infer_ready;
  logic [IW-1:0] winner_id;
  logic [IW-1:0] result_id;
  logic          result_valid;
  logic          busy;
  logic          error;

  snn_inference_sequencer #(
    .NUM_INPUTS(NI), .ADDR_W(AW), .DAT_W(DW), .NUM_STEPS(NS), .ID_W(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .host_dat(host_dat), .host_valid(host_valid),
    .host_ready(host_ready), .load_addr(load_addr), .load_en(load_en), .load_dat(load_dat),
    .pre_processing_done(pre_processing_done), .current_step_finished(current_step_finished),
    .get_winner(get_winner), .infer_ready(infer_ready), .winner_id(winner_id),
    .result_id(result_id), .result_valid(result_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic          s, c, ir;
    logic [IW-1:0] w;
    logic          e_ppd, e_gw, e_busy, e_rv, e_hr;
    logic [IW-1:0] e_rid;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_host_ready"}, 32'(host_ready), 0);
    chk({tag, "_load_en"}, 32'(load_en), 0);
    chk({tag, "_load_addr"}, 32'(load_addr), 0);
    chk({tag, "_load_dat"}, 32'(load_dat), 0);
    chk({tag, "_ppd"}, 32'(pre_processing_done), 0);
    chk({tag, "_get_winner"}, 32'(get_winner), 0);
    chk({tag, "_result_id"}, 32'(result_id), 0);
    chk({tag, "_result_valid"}, 32'(result_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_host_ready", 32'(host_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_result_valid", 32'(result_valid), 0);
    chk("start_error", 32'(error), 0);
  endtask

  // streams NI values; scoreboard checks address order and data; optional abort at an address
  task automatic run_load(input bit toggle, input bit noise, input int abort_at);
    int  nw = 0;
    int  exp_addr = 0;
    bit  ph = 1'b0;
    sb.delete();
    for (int cyc = 0; cyc < 4000 && nw < NI; cyc++) begin
      logic          v;
      logic [DW-1:0] d;
      wr_t           e;
      v = toggle ? ph : 1'b1;
      ph = ~ph;
      d = DW'($urandom);
      host_valid = v;
      host_dat = d;
      current_step_finished = noise ? 1'($urandom) : 1'b0;
      infer_ready = noise ? 1'($urandom) : 1'b0;
      if (v && host_ready) begin
        sb.push_back({AW'(exp_addr), d});
        exp_addr++;
      end
      tick();
      if (load_en) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL load_unexpected: got write at %0d expected none", load_addr);
        end else begin
          e = sb.pop_front();
          chk("load_addr", 32'(load_addr), 32'(e.a));
          chk("load_dat", 32'(load_dat), 32'(e.d));
        end
        nw++;
        if (abort_at >= 0 && int'(load_addr) == abort_at) begin
          current_step_finished = 1'b0;
          infer_ready = 1'b0;
          return;
        end
      end
    end
    current_step_finished = 1'b0;
    infer_ready = 1'b0;
    chk("write_count", 32'(nw), NI);
    chk("host_ready_at_last", 32'(host_ready), 0);
    chk("sb_empty", 32'(sb.size()), 0);
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].s;
      current_step_finished = tbl[i].c;
      infer_ready = tbl[i].ir;
      winner_id = tbl[i].w;
      tick();
      chk($sformatf("%s_r%0d_ppd", tag, i), 32'(pre_processing_done), 32'(tbl[i].e_ppd));
      chk($sformatf("%s_r%0d_gw", tag, i), 32'(get_winner), 32'(tbl[i].e_gw));
      chk($sformatf("%s_r%0d_busy", tag, i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("%s_r%0d_rv", tag, i), 32'(result_valid), 32'(tbl[i].e_rv));
      chk($sformatf("%s_r%0d_hr", tag, i), 32'(host_ready), 32'(tbl[i].e_hr));
      chk($sformatf("%s_r%0d_le", tag, i), 32'(load_en), 0);
      chk($sformatf("%s_r%0d_err", tag, i), 32'(error), 0);
      if (tbl[i].e_rv) chk($sformatf("%s_r%0d_rid", tag, i), 32'(result_id), 32'(tbl[i].e_rid));
    end
    start = 1'b0;
    current_step_finished = 1'b0;
    infer_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // starts in KICK after the last write: {s,c,ir,w, ppd,gw,busy,rv,hr, rid}
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};  // step+ready in KICK ignored
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};  // step 1, ready in RUN ignored
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};  // start in RUN ignored
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};  // step 2
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};  // step 3
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};  // step 4 -> get_winner
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd17}; // winner latched
    tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd17}; // ready in DONE ignored
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd17}; // result holds

    rst_n = 1'b0;
    start = 1'b0;
    host_valid = 1'b0;
    host_dat = '0;
    current_step_finished = 1'b0;
    infer_ready = 1'b0;
    winner_id = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // abort mid-LOAD at address 500
    do_start();
    run_load(1'b0, 1'b0, 500);
    chk("abort_addr", 32'(load_addr), 500);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    host_valid = 1'b0;
    tick();
    chk("midreset_idle_busy", 32'(busy), 0);

    // full pass, valid always high
    do_start();
    run_load(1'b0, 1'b0, -1);
    apply_table("p1");

    // start in DONE: new pass with toggled valid and stray step/ready pulses during LOAD
    do_start();
    run_load(1'b1, 1'b1, -1);
    apply_table("p2");

`ifdef SNN_SEQ_WATCHDOG_EN
    begin
      int n = 0;
      do_start();
      run_load(1'b0, 1'b0, -1);
      host_valid = 1'b0;
      while (!error && n < 100) begin
        tick();
        n++;
      end
      chk("wd_latency", 32'(n - 1), TO);
      chk("wd_error", 32'(error), 1);
      chk("wd_busy", 32'(busy), 0);
      chk("wd_result_valid", 32'(result_valid), 0);
      tick();
      chk("wd_error_hold", 32'(error), 1);
      do_start();
      chk("wd_error_clear", 32'(error), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
